// File: rtl/mem_access.sv
// Memory-access pipeline stage: issues one load/store per instruction over a req/ack port and registers write-back.
// Latency: 1 cycle for ALU-only or misaligned ops, 2+ cycles for memory ops (1 issue cycle plus the wait for ack).
// Backpressure: stall is raised combinationally while a memory op waits for ack; optional MEM_ALIGN_CHECK_EN flags misalignment.
`ifndef RegDataBus
`define RegDataBus 31:0
`endif

module mem_access (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              m_mem_read,
    input  logic              m_mem_write,
    input  logic              m_mem_to_reg,
    input  logic              m_write_reg,
    input  logic [4:0]        m_write_addr,
    input  logic [1:0]        m_size,
    input  logic              m_sign_ext,
    input  logic [`RegDataBus] alu_result,
    input  logic [`RegDataBus] store_data,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              w_valid,
    output logic              w_mem_to_reg,
    output logic              w_write_reg,
    output logic [4:0]        w_write_addr,
    output logic [`RegDataBus] data_from_mem,
    output logic [`RegDataBus] alu_result_out,
    output logic              w_misalign
);

    typedef enum logic {IDLE, REQ} state_t;

    state_t      state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic        w_valid_q, w_valid_d;
    logic        w_mem_to_reg_q, w_mem_to_reg_d;
    logic        w_write_reg_q, w_write_reg_d;
    logic [4:0]  w_write_addr_q, w_write_addr_d;
    logic [31:0] data_from_mem_q, data_from_mem_d;
    logic [31:0] alu_result_out_q, alu_result_out_d;
    logic        w_misalign_q, w_misalign_d;

    logic        is_memop, is_load, misalign, go_mem;
    logic [31:0] st_wdata, ld_data;
    logic [3:0]  st_be;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        is_memop = m_mem_read | m_mem_write;
        is_load  = m_mem_read;
`ifdef MEM_ALIGN_CHECK_EN
        misalign = is_memop & (((m_size == 2'b01) & alu_result[0]) |
                               (m_size[1] & (alu_result[1:0] != 2'b00)));
`else
        misalign = 1'b0;
`endif
        go_mem = in_valid & is_memop & ~misalign;
        stall  = go_mem & ~((state_q == REQ) & mem_ack);
    end

    // Store lane replication and byte enables; loads always read the full word.
    always_comb begin
        st_wdata = store_data;
        st_be    = 4'b1111;
        case (m_size)
            2'b00: begin
                st_wdata = {4{store_data[7:0]}};
                st_be    = 4'b0001 << alu_result[1:0];
            end
            2'b01: begin
                st_wdata = {2{store_data[15:0]}};
                st_be    = 4'b0011 << {alu_result[1], 1'b0};
            end
            default: begin
                st_wdata = store_data;
                st_be    = 4'b1111;
            end
        endcase
    end

    always_comb begin
        ld_byte = mem_rdata[7:0];
        case (alu_result[1:0])
            2'b00:   ld_byte = mem_rdata[7:0];
            2'b01:   ld_byte = mem_rdata[15:8];
            2'b10:   ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = alu_result[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (m_size)
            2'b00:   ld_data = {{24{m_sign_ext & ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = {{16{m_sign_ext & ld_half[15]}}, ld_half};
            default: ld_data = mem_rdata;
        endcase
    end

    always_comb begin
        state_d          = state_q;
        mem_req_d        = mem_req_q;
        mem_we_d         = mem_we_q;
        mem_addr_d       = mem_addr_q;
        mem_wdata_d      = mem_wdata_q;
        mem_be_d         = mem_be_q;
        w_valid_d        = 1'b0;
        w_mem_to_reg_d   = w_mem_to_reg_q;
        w_write_reg_d    = w_write_reg_q;
        w_write_addr_d   = w_write_addr_q;
        data_from_mem_d  = data_from_mem_q;
        alu_result_out_d = alu_result_out_q;
        w_misalign_d     = w_misalign_q;
        case (state_q)
            IDLE: begin
                if (go_mem) begin
                    state_d     = REQ;
                    mem_req_d   = 1'b1;
                    mem_we_d    = ~is_load;
                    mem_addr_d  = {alu_result[31:2], 2'b00};
                    mem_wdata_d = st_wdata;
                    mem_be_d    = is_load ? 4'b1111 : st_be;
                end else if (in_valid) begin
                    w_valid_d        = 1'b1;
                    w_mem_to_reg_d   = m_mem_to_reg;
                    w_write_reg_d    = m_write_reg & ~misalign;
                    w_write_addr_d   = m_write_addr;
                    data_from_mem_d  = 32'h0;
                    alu_result_out_d = alu_result;
                    w_misalign_d     = misalign;
                end
            end
            default: begin
                // Upstream is frozen while we wait, so the instruction inputs are still valid here.
                if (mem_ack) begin
                    state_d          = IDLE;
                    mem_req_d        = 1'b0;
                    mem_we_d         = 1'b0;
                    w_valid_d        = 1'b1;
                    w_mem_to_reg_d   = m_mem_to_reg;
                    w_write_reg_d    = m_write_reg;
                    w_write_addr_d   = m_write_addr;
                    data_from_mem_d  = is_load ? ld_data : 32'h0;
                    alu_result_out_d = alu_result;
                    w_misalign_d     = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            mem_req_q        <= 1'b0;
            mem_we_q         <= 1'b0;
            mem_addr_q       <= 32'h0;
            mem_wdata_q      <= 32'h0;
            mem_be_q         <= 4'h0;
            w_valid_q        <= 1'b0;
            w_mem_to_reg_q   <= 1'b0;
            w_write_reg_q    <= 1'b0;
            w_write_addr_q   <= 5'h0;
            data_from_mem_q  <= 32'h0;
            alu_result_out_q <= 32'h0;
            w_misalign_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            mem_req_q        <= mem_req_d;
            mem_we_q         <= mem_we_d;
            mem_addr_q       <= mem_addr_d;
            mem_wdata_q      <= mem_wdata_d;
            mem_be_q         <= mem_be_d;
            w_valid_q        <= w_valid_d;
            w_mem_to_reg_q   <= w_mem_to_reg_d;
            w_write_reg_q    <= w_write_reg_d;
            w_write_addr_q   <= w_write_addr_d;
            data_from_mem_q  <= data_from_mem_d;
            alu_result_out_q <= alu_result_out_d;
            w_misalign_q     <= w_misalign_d;
        end
    end

    assign mem_req        = mem_req_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign mem_be         = mem_be_q;
    assign w_valid        = w_valid_q;
    assign w_mem_to_reg   = w_mem_to_reg_q;
    assign w_write_reg    = w_write_reg_q;
    assign w_write_addr   = w_write_addr_q;
    assign data_from_mem  = data_from_mem_q;
    assign alu_result_out = alu_result_out_q;
    assign w_misalign     = w_misalign_q;

endmodule
